// File: rtl/adder_mem_pkg.sv
// Shared types and defaults for the adding-machine memory responder.
// Optional build macro: ADDER_MEM_PARITY_EN (stored even-parity column).
package adder_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } dir_e;

endpackage

// File: rtl/adder_mem_responder_if.sv
// Controller <-> memory responder bus: strobes, addresses and results.
// Optional build macro: ADDER_MEM_PARITY_EN (drives parity_err).
interface adder_mem_responder_if #(
    parameter int DATA_W = adder_mem_pkg::DATA_W,
    parameter int ADDR_W = adder_mem_pkg::ADDR_W
);
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] ir_addr;
    logic              pc_on_adr;
    logic              ir_on_adr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              done;
    logic              addr_err;
    logic              parity_err;

    modport master (
        output pc_addr, ir_addr, pc_on_adr, ir_on_adr,
        output mem_read, mem_write, wdata,
        input  rdata, rvalid, busy, done, addr_err, parity_err
    );

    modport slave (
        input  pc_addr, ir_addr, pc_on_adr, ir_on_adr,
        input  mem_read, mem_write, wdata,
        output rdata, rvalid, busy, done, addr_err, parity_err
    );

endinterface

// File: rtl/adder_mem_array.sv
// Word array: sync write, registered read, async clear on reset.
// Optional build macro: ADDER_MEM_PARITY_EN (even-parity bit per word).
module adder_mem_array
    import adder_mem_pkg::*;
#(
    parameter int DATA_W = adder_mem_pkg::DATA_W,
    parameter int ADDR_W = adder_mem_pkg::ADDR_W,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              perr_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Word storage; reset wipes every location.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef ADDER_MEM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             perr_q;

    // Parity column written alongside the data word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q <= '0;
        end else if (we_i) begin
            par_q[addr_i] <= ^wdata_i;
        end
    end

    // Mismatch flag lives for exactly the cycle after a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= re_i & ((^mem_q[addr_i]) ^ par_q[addr_i]);
        end
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/adder_mem_responder.sv
// Memory-side responder: address mux, request checks, wait-state FSM.
// Optional build macro: ADDER_MEM_PARITY_EN (read parity checking).
module adder_mem_responder
    import adder_mem_pkg::*;
#(
    parameter int DATA_W      = adder_mem_pkg::DATA_W,
    parameter int ADDR_W      = adder_mem_pkg::ADDR_W,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    adder_mem_responder_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dir_e              dir_q, dir_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              rd_req, wr_req, in_idle;
    logic              illegal, accept;
    logic [ADDR_W-1:0] sel_addr;
    logic              go_resp, arr_we, arr_re;
    logic              busy_c, done_c, rvalid_c;

    assign rd_req   = bus.pc_on_adr | bus.mem_read;
    assign wr_req   = bus.mem_write;
    assign sel_addr = bus.pc_on_adr ? bus.pc_addr : bus.ir_addr;
    assign in_idle  = (state_q == IDLE);

    // Request screening: only IDLE looks at the strobes.
    always_comb begin
        illegal = 1'b0;
        if (in_idle) begin
            illegal = (rd_req & wr_req)
                    | (bus.pc_on_adr & bus.ir_on_adr)
                    | ((rd_req | wr_req)
                       & ({1'b0, sel_addr} >= DEPTH_V));
        end
        accept = in_idle & (rd_req | wr_req) & ~illegal;
    end

    // Capture address, direction and data on accept.
    always_comb begin
        addr_d  = accept ? sel_addr : addr_q;
        dir_d   = accept ? (wr_req ? REQ_WR : REQ_RD) : dir_q;
        wdata_d = accept ? bus.wdata : wdata_q;
        err_d   = err_q | illegal;
    end

    // Request latches and sticky address error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            dir_q   <= REQ_RD;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: optional wait states, then one RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy_c   = (state_q != IDLE);
        done_c   = (state_q == RESP);
        rvalid_c = done_c & (dir_q == REQ_RD);
    end

    // Array access happens on the edge that enters RESP.
    assign go_resp = (state_d == RESP);
    assign arr_we  = go_resp & (dir_d == REQ_WR);
    assign arr_re  = go_resp & (dir_d == REQ_RD);

    adder_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_arr (
        .clock   (clock),
        .reset   (reset),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (addr_d),
        .wdata_i (wdata_d),
        .rdata_o (bus.rdata),
        .perr_o  (bus.parity_err)
    );

    assign bus.rvalid   = rvalid_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.addr_err = err_q;

endmodule

// File: tb/tb_adder_mem_responder.sv
// Directed bench for adder_mem_responder (WAIT=1/DEPTH=24 and WAIT=0).
// Optional build macro: ADDER_MEM_PARITY_EN (parity injection case).
module tb_adder_mem_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ADDER_MEM_PARITY_EN
    localparam logic PERR_EXP = 1'b1;
    logic [23:0] pv;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    adder_mem_responder_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
    adder_mem_responder_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();

    adder_mem_responder #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(24), .WAIT_CYCLES(1)
    ) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    adder_mem_responder #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(32), .WAIT_CYCLES(0)
    ) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    // flags: rvalid busy done addr_err parity_err
    logic [4:0] fl0, fl1;
    assign fl0 = {bus0.rvalid, bus0.busy, bus0.done,
                  bus0.addr_err, bus0.parity_err};
    assign fl1 = {bus1.rvalid, bus1.busy, bus1.done,
                  bus1.addr_err, bus1.parity_err};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clock);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Present strobes for one accept edge, then drop them.
    task automatic req0(input logic pc, input logic ir,
                        input logic rd, input logic wr,
                        input logic [4:0] pa, input logic [4:0] ia,
                        input logic [7:0] wd);
        @(negedge clock);
        bus0.pc_on_adr = pc;
        bus0.ir_on_adr = ir;
        bus0.mem_read  = rd;
        bus0.mem_write = wr;
        bus0.pc_addr   = pa;
        bus0.ir_addr   = ia;
        bus0.wdata     = wd;
        @(posedge clock);
        #1;
        bus0.pc_on_adr = 1'b0;
        bus0.ir_on_adr = 1'b0;
        bus0.mem_read  = 1'b0;
        bus0.mem_write = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        bus1.ir_on_adr = 1'b1;
        bus1.mem_write = 1'b1;
        bus1.ir_addr   = a;
        bus1.wdata     = d;
        @(posedge clock);
        #1;
        bus1.ir_on_adr = 1'b0;
        bus1.mem_write = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.pc_on_adr = 0; bus0.ir_on_adr = 0;
        bus0.mem_read  = 0; bus0.mem_write = 0;
        bus0.pc_addr   = 0; bus0.ir_addr   = 0;
        bus0.wdata     = 0;
        bus1.pc_on_adr = 0; bus1.ir_on_adr = 0;
        bus1.mem_read  = 0; bus1.mem_write = 0;
        bus1.pc_addr   = 0; bus1.ir_addr   = 0;
        bus1.wdata     = 0;

        #12;
        chk("rst_fl0", 32'(fl0), 32'h0);
        chk("rst_rd0", 32'(bus0.rdata), 32'h0);
        chk("rst_fl1", 32'(fl1), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // reset in the middle of a write's wait state
        req0(0, 1, 0, 1, 0, 3, 8'hAA);
        chk("w3_wait", 32'(fl0), 32'b01000);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_fl", 32'(fl0), 32'h0);
        chk("midrst_rd", 32'(bus0.rdata), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        req0(0, 1, 1, 0, 0, 3, 8'h00);
        tick();
        chk("r3_fl", 32'(fl0), 32'b11100);
        chk("r3_data", 32'(bus0.rdata), 32'h00);
        tick();

        // write then fetch, wdata moved after accept
        req0(0, 1, 0, 1, 0, 5, 8'h3C);
        chk("w5_wait", 32'(fl0), 32'b01000);
        bus0.wdata = 8'hFF;
        tick();
        chk("w5_resp", 32'(fl0), 32'b01100);
        tick();
        chk("w5_idle", 32'(fl0), 32'b00000);
        req0(1, 0, 0, 0, 5, 0, 8'h00);
        chk("f5_wait", 32'(fl0), 32'b01000);
        tick();
        chk("f5_resp", 32'(fl0), 32'b11100);
        chk("f5_data", 32'(bus0.rdata), 32'h3C);
        tick();
        chk("f5_idle", 32'(fl0), 32'b00000);
        chk("f5_hold", 32'(bus0.rdata), 32'h3C);

        // read+write conflict leaves memory alone
        req0(0, 1, 0, 1, 0, 9, 8'h5A);
        tick();
        tick();
        req0(0, 1, 1, 1, 0, 9, 8'h77);
        chk("rdwr_fl", 32'(fl0), 32'b00010);
        tick();
        chk("rdwr_nodone", 32'(fl0), 32'b00010);
        req0(0, 1, 1, 0, 0, 9, 8'h00);
        tick();
        chk("r9_fl", 32'(fl0), 32'b11110);
        chk("r9_data", 32'(bus0.rdata), 32'h5A);
        tick();

        // pc and ir selects together
        rst_pulse();
        chk("err_clr", 32'(fl0), 32'h0);
        req0(1, 1, 1, 0, 4, 4, 8'h00);
        chk("pcir_fl", 32'(fl0), 32'b00010);
        tick();
        chk("pcir_nodone", 32'(fl0), 32'b00010);

        // address range edges with DEPTH=24
        rst_pulse();
        req0(0, 1, 1, 0, 0, 23, 8'h00);
        tick();
        chk("r23_fl", 32'(fl0), 32'b11100);
        tick();
        req0(0, 1, 1, 0, 0, 24, 8'h00);
        chk("r24_fl", 32'(fl0), 32'b00010);
        rst_pulse();
        req0(0, 1, 1, 0, 0, 25, 8'h00);
        chk("r25_fl", 32'(fl0), 32'b00010);
        tick();
        chk("r25_nodone", 32'(fl0), 32'b00010);

        // strobes held through WAIT and RESP are ignored
        rst_pulse();
        req0(0, 1, 0, 1, 0, 2, 8'h44);
        chk("bi_wait", 32'(fl0), 32'b01000);
        bus0.ir_on_adr = 1'b1;
        bus0.mem_write = 1'b1;
        bus0.ir_addr   = 5'd2;
        bus0.wdata     = 8'h99;
        tick();
        chk("bi_resp", 32'(fl0), 32'b01100);
        tick();
        chk("bi_idle", 32'(fl0), 32'b00000);
        bus0.ir_on_adr = 1'b0;
        bus0.mem_write = 1'b0;
        tick();
        chk("bi_once", 32'(fl0), 32'b00000);
        req0(0, 1, 1, 0, 0, 2, 8'h00);
        tick();
        chk("r2_data", 32'(bus0.rdata), 32'h44);
        tick();

        // parity error injection on address 7
        req0(0, 1, 0, 1, 0, 7, 8'h0F);
        tick();
        tick();
`ifdef ADDER_MEM_PARITY_EN
        pv = u_dut0.u_arr.par_q;
        pv[7] = ~pv[7];
        force u_dut0.u_arr.par_q = pv;
`endif
        req0(0, 1, 1, 0, 0, 7, 8'h00);
        tick();
        chk("r7_data", 32'(bus0.rdata), 32'h0F);
        chk("r7_fl", 32'(fl0), 32'({4'b1110, PERR_EXP}));
        tick();
        chk("r7_after", 32'(fl0), 32'b00000);
`ifdef ADDER_MEM_PARITY_EN
        release u_dut0.u_arr.par_q;
`endif

        // zero wait: back-to-back reads
        wr1(0, 8'h11);
        chk("z_w0", 32'(fl1), 32'b01100);
        tick();
        wr1(1, 8'h22);
        chk("z_w1", 32'(fl1), 32'b01100);
        tick();
        @(negedge clock);
        bus1.ir_on_adr = 1'b1;
        bus1.mem_read  = 1'b1;
        bus1.ir_addr   = 5'd0;
        tick();
        chk("z_r0_fl", 32'(fl1), 32'b11100);
        chk("z_r0_d", 32'(bus1.rdata), 32'h11);
        bus1.ir_addr = 5'd1;
        tick();
        chk("z_gap", 32'(fl1), 32'b00000);
        tick();
        bus1.ir_on_adr = 1'b0;
        bus1.mem_read  = 1'b0;
        chk("z_r1_fl", 32'(fl1), 32'b11100);
        chk("z_r1_d", 32'(bus1.rdata), 32'h22);
        tick();
        chk("z_idle", 32'(fl1), 32'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
